// File: rtl/ssd_capture_if.sv
// Display-side bundle for ssd_capture: the multiplexed segment/anode lines
// coming in and the reconstructed digit value going out.
`timescale 1ns/1ps
interface ssd_capture_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_ok;
  logic        frame_strobe;
  logic        frame_valid;
  logic        blank;

  modport master (
    output seg, an,
    input  digits, digit_ok, frame_strobe, frame_valid, blank
  );

  modport slave (
    input  seg, an,
    output digits, digit_ok, frame_strobe, frame_valid, blank
  );
endinterface

// File: rtl/ssd_capture.sv
// Reconstructs the four hex digits shown on a multiplexed, active-low,
// common-anode seven-segment display by watching its segment and anode pins.
`timescale 1ns/1ps
module ssd_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input logic          clk,
  input logic          rst,
  ssd_capture_if.slave bus
);

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES);

  // Returns {legal, nibble}; anything not in the glyph set (including dark) is illegal.
  function automatic logic [4:0] decodeGlyph(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [10:0]   r_sync1;
  logic [10:0]   r_sync2;
  logic [10:0]   r_prev;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic [15:0]   r_digits;
  logic [3:0]    r_ok;
  logic [3:0]    r_mask;
  logic          r_strobe;
  logic          r_valid;
  logic          r_blank;
  logic [TW-1:0] r_idle;

  logic          w_sel;
  logic [1:0]    w_idx;
  logic          w_clear;
  logic          w_capture;
  logic [4:0]    w_dec;
  logic [15:0]   w_newDigits;
  logic [3:0]    w_newOk;
  logic [3:0]    w_newMask;
  logic          w_frameDone;
  logic [TW-1:0] w_idleNext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {bus.an, bus.seg};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_comb begin
    w_sel = 1'b0;
    case (r_sync2[10:7])
      4'b1110, 4'b1101, 4'b1011, 4'b0111: w_sel = 1'b1;
      default:                            w_sel = 1'b0;
    endcase
  end

  // A capture always comes from r_prev, the sample that has dwelt long enough.
  always_comb begin
    w_idx = 2'd0;
    case (r_prev[10:7])
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  assign w_clear   = (r_sync2 != r_prev) || !w_sel;
  assign w_capture = (r_cnt == CNT_MAX) && !r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (w_clear) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture) begin
        r_done <= 1'b1;
      end
    end
  end

  always_comb begin
    w_dec       = decodeGlyph(r_prev[6:0]);
    w_newDigits = r_digits;
    w_newOk     = r_ok;
    for (int k = 0; k < 4; k++) begin
      if (w_idx == 2'(k)) begin
        w_newDigits[4*k +: 4] = w_dec[3:0];
        w_newOk[k]            = w_dec[4];
      end
    end
    w_newMask   = r_mask | (4'b0001 << w_idx);
    w_frameDone = &w_newMask;
    w_idleNext  = (r_idle == IDLE_MAX) ? IDLE_MAX : r_idle + 1'b1;
  end

  // A capture wins over a timeout landing on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digits <= '0;
      r_ok     <= '0;
      r_mask   <= '0;
      r_strobe <= 1'b0;
      r_valid  <= 1'b0;
      r_blank  <= 1'b0;
      r_idle   <= '0;
    end else if (w_capture) begin
      r_digits <= w_newDigits;
      r_ok     <= w_newOk;
      r_blank  <= 1'b0;
      r_idle   <= '0;
      if (w_frameDone) begin
        r_mask   <= '0;
        r_strobe <= 1'b1;
        r_valid  <= &w_newOk;
      end else begin
        r_mask   <= w_newMask;
        r_strobe <= 1'b0;
      end
    end else begin
      r_strobe <= 1'b0;
      r_idle   <= w_idleNext;
      if (w_idleNext == IDLE_MAX) begin
        r_blank <= 1'b1;
        r_valid <= 1'b0;
        r_mask  <= '0;
      end
    end
  end

  assign bus.digits       = r_digits;
  assign bus.digit_ok     = r_ok;
  assign bus.frame_strobe = r_strobe;
  assign bus.frame_valid  = r_valid;
  assign bus.blank        = r_blank;

endmodule

// File: tb/tb_ssd_capture.sv
// Bench for ssd_capture: directed display scans plus random segment/anode
// traffic, checked every cycle against a sample-history model.
`timescale 1ns/1ps
module tb_ssd_capture;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 2048;
  localparam int DWELL   = 40;
  localparam int HLEN    = SETTLE + 4;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clk;
  logic rst;

  ssd_capture_if bus();

  ssd_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Model: hist[j] is the {an,seg} value sampled j edges ago (zeros before reset).
  logic [10:0] hist [HLEN];
  int          mIdle;
  logic [15:0] mDigits;
  logic [3:0]  mOk;
  logic [3:0]  mMask;
  logic        mStrobe;
  logic        mFv;
  logic        mBlank;

  int checks = 0;
  int errors = 0;
  int strobeSeen = 0;

  function automatic logic isSelectable(input logic [10:0] v);
    return $countones(~v[10:7]) == 1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < HLEN; i++) hist[i] = '0;
      mIdle   = 0;
      mDigits = '0;
      mOk     = '0;
      mMask   = '0;
      mStrobe = 1'b0;
      mFv     = 1'b0;
      mBlank  = 1'b0;
    end else begin
      logic       cap;
      int         k;
      logic       gOk;
      logic [3:0] gNib;
      for (int i = HLEN - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {bus.an, bus.seg};
      // Capture exactly when a selectable value has been seen for SETTLE samples in a row.
      cap = isSelectable(hist[3]) && (hist[3+SETTLE] != hist[3]);
      for (int i = 4; i < 3 + SETTLE; i++) if (hist[i] != hist[3]) cap = 1'b0;
      mStrobe = 1'b0;
      if (cap) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (!hist[3][7+i]) k = i;
        gOk  = 1'b0;
        gNib = 4'h0;
        for (int g = 0; g < 16; g++) begin
          if (GLYPH[g] == hist[3][6:0]) begin
            gOk  = 1'b1;
            gNib = 4'(g);
          end
        end
        mDigits[4*k +: 4] = gNib;
        mOk[k]   = gOk;
        mMask[k] = 1'b1;
        if (mMask == 4'hF) begin
          mMask   = 4'h0;
          mStrobe = 1'b1;
          mFv     = &mOk;
        end
        mBlank = 1'b0;
        mIdle  = 0;
      end else begin
        mIdle++;
        if (mIdle >= TIMEOUT) begin
          mBlank = 1'b1;
          mFv    = 1'b0;
          mMask  = 4'h0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("digits",       32'(bus.digits),       32'(mDigits));
    checkOutput("digit_ok",     32'(bus.digit_ok),     32'(mOk));
    checkOutput("frame_strobe", 32'(bus.frame_strobe), 32'(mStrobe));
    checkOutput("frame_valid",  32'(bus.frame_valid),  32'(mFv));
    checkOutput("blank",        32'(bus.blank),        32'(mBlank));
  endtask

  // Drive one pattern, then spend the given number of cycles comparing at each negedge.
  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int cycles);
    bus.an  = a;
    bus.seg = s;
    repeat (cycles) begin
      @(negedge clk);
      compareAll();
      if (bus.frame_strobe) strobeSeen++;
    end
  endtask

  task automatic scanDigits(input logic [15:0] v, input logic [3:0] dark, input int first, input int last);
    for (int d = first; d <= last; d++) begin
      applyStimulus(~(4'b0001 << d), dark[d] ? 7'h7F : GLYPH[v[4*d +: 4]], DWELL);
    end
  endtask

  initial begin
    int base;
    rst     = 1'b0;
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    applyStimulus(4'hF, 7'h7F, 3);
    checkOutput("reset digits", 32'(bus.digits), 32'h0);
    checkOutput("reset ok",     32'(bus.digit_ok), 32'h0);
    checkOutput("reset strobe", 32'(bus.frame_strobe), 32'h0);
    checkOutput("reset valid",  32'(bus.frame_valid), 32'h0);
    checkOutput("reset blank",  32'(bus.blank), 32'h0);
    rst = 1'b1;

    $display("[TB] full scan of 3A7F");
    base = strobeSeen;
    scanDigits(16'h3A7F, 4'b0000, 0, 3);
    checkOutput("scan1 digits",  32'(bus.digits), 32'h3A7F);
    checkOutput("scan1 ok",      32'(bus.digit_ok), 32'hF);
    checkOutput("scan1 valid",   32'(bus.frame_valid), 32'h1);
    checkOutput("scan1 blank",   32'(bus.blank), 32'h0);
    checkOutput("scan1 strobes", 32'(strobeSeen - base), 32'd1);

    $display("[TB] capture latency");
    applyStimulus(4'b1110, 7'b0100100, DWELL);
    checkOutput("lat first",  32'(bus.digits[3:0]), 32'h5);
    applyStimulus(4'b1110, 7'b1001111, SETTLE + 2);
    checkOutput("lat edge18", 32'(bus.digits[3:0]), 32'h5);
    applyStimulus(4'b1110, 7'b1001111, 1);
    checkOutput("lat edge19", 32'(bus.digits[3:0]), 32'h1);

    $display("[TB] glitching digit 2");
    base = strobeSeen;
    for (int i = 0; i < 8; i++) applyStimulus(4'b1011, GLYPH[(i % 2) + 1], 10);
    checkOutput("glitch digit2",  32'(bus.digits[11:8]), 32'hA);
    checkOutput("glitch strobes", 32'(strobeSeen - base), 32'd0);
    applyStimulus(4'b1011, 7'b0110000, 30);
    checkOutput("settled digit2", 32'(bus.digits[11:8]), 32'hE);

    $display("[TB] dark digit 1");
    base = strobeSeen;
    scanDigits(16'h1234, 4'b0010, 0, 3);
    checkOutput("dark digits",  32'(bus.digits), 32'h1204);
    checkOutput("dark ok",      32'(bus.digit_ok), 32'b1101);
    checkOutput("dark valid",   32'(bus.frame_valid), 32'h0);
    checkOutput("dark strobes", 32'(strobeSeen - base), 32'd1);

    $display("[TB] timeout and recovery");
    scanDigits(16'h3A7F, 4'b0000, 0, 3);
    applyStimulus(4'hF, 7'h7F, TIMEOUT + 40);
    checkOutput("to blank",  32'(bus.blank), 32'h1);
    checkOutput("to valid",  32'(bus.frame_valid), 32'h0);
    checkOutput("to digits", 32'(bus.digits), 32'h3A7F);
    base = strobeSeen;
    scanDigits(16'h5C00, 4'b0000, 0, 0);
    checkOutput("resume blank", 32'(bus.blank), 32'h0);
    scanDigits(16'h5C00, 4'b0000, 1, 3);
    checkOutput("resume digits",  32'(bus.digits), 32'h5C00);
    checkOutput("resume valid",   32'(bus.frame_valid), 32'h1);
    checkOutput("resume strobes", 32'(strobeSeen - base), 32'd1);

    $display("[TB] reset mid-frame");
    scanDigits(16'h1111, 4'b0000, 0, 1);
    rst = 1'b0;
    applyStimulus(4'b1101, GLYPH[1], 1);
    checkOutput("midrst digits", 32'(bus.digits), 32'h0);
    checkOutput("midrst ok",     32'(bus.digit_ok), 32'h0);
    checkOutput("midrst valid",  32'(bus.frame_valid), 32'h0);
    checkOutput("midrst blank",  32'(bus.blank), 32'h0);
    rst = 1'b1;
    base = strobeSeen;
    scanDigits(16'h1111, 4'b0000, 2, 3);
    checkOutput("half strobes", 32'(strobeSeen - base), 32'd0);
    scanDigits(16'h1111, 4'b0000, 0, 1);
    checkOutput("full strobes", 32'(strobeSeen - base), 32'd1);
    checkOutput("full digits",  32'(bus.digits), 32'h1111);

    $display("[TB] random traffic");
    for (int r = 0; r < 60; r++) begin
      logic [3:0] a;
      logic [6:0] s;
      if ($urandom_range(0, 4) != 0) a = ~(4'b0001 << $urandom_range(0, 3));
      else                           a = 4'($urandom);
      if ($urandom_range(0, 4) != 0) s = GLYPH[4'($urandom_range(0, 15))];
      else                           s = 7'($urandom);
      applyStimulus(a, s, int'($urandom_range(3, 40)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
